// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the CPU memory-port arbiter.
package cpu_mem_pkg;
  localparam int ADDR_W           = 32;
  localparam int DWORD_W          = 32;
  localparam int IWORD_W          = 48;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_e;
endpackage

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the data and fetch ports onto one single-outstanding memory port.
// Data wins unless a waiting fetch has been passed over STARVE_LIMIT times.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DWORD_W-1:0] d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [DWORD_W-1:0] d_rdata,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic               i_flush,
  output logic               i_gnt,
  output logic               i_rvalid,
  output logic [IWORD_W-1:0] i_rdata,
  output logic               m_req,
  output logic               m_we,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [IWORD_W-1:0] m_wdata,
  input  logic               m_ack,
  input  logic [IWORD_W-1:0] m_rdata
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIMIT);

  state_e               r_state, w_next;
  logic [STARVE_W-1:0]  r_starve;
  logic                 r_m_req, r_m_we, r_flush;
  logic [ADDR_W-1:0]    r_m_addr;
  logic [IWORD_W-1:0]   r_m_wdata;
  logic                 r_d_rvalid, r_i_rvalid;
  logic [DWORD_W-1:0]   r_d_rdata;
  logic [IWORD_W-1:0]   r_i_rdata;
  logic                 w_fetch_due, w_dgnt, w_ignt, w_ack;

  assign w_fetch_due = i_req && (r_starve == LIM);
  // acks only mean something while a transaction is outstanding
  assign w_ack       = m_ack && (r_state != IDLE);

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (w_dgnt) w_next = DATA;
                  else if (w_ignt) w_next = INST;
      DATA, INST: if (m_ack) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // grants are combinational and gated by reset so they drop immediately
  always_comb begin
    w_dgnt = 1'b0;
    w_ignt = 1'b0;
    if (!rst_b && r_state == IDLE) begin
      if (d_req && !w_fetch_due) w_dgnt = 1'b1;
      else if (i_req)            w_ignt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_flush    <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rdata  <= '0;
      r_i_rdata  <= '0;
    end else begin
      r_d_rvalid <= 1'b0;
      r_i_rvalid <= 1'b0;
      if (w_dgnt) begin
        r_m_req   <= 1'b1;
        r_m_we    <= d_we;
        r_m_addr  <= d_addr;
        r_m_wdata <= d_we ? {{(IWORD_W-DWORD_W){1'b0}}, d_wdata} : '0;
      end else if (w_ignt) begin
        r_m_req   <= 1'b1;
        r_m_we    <= 1'b0;
        r_m_addr  <= i_addr;
        r_m_wdata <= '0;
        r_flush   <= i_flush;
      end else if (w_ack) begin
        r_m_req <= 1'b0;
        if (r_state == DATA && !r_m_we) begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= m_rdata[DWORD_W-1:0];
        end
        // a flush in the ack cycle itself still kills the response
        if (r_state == INST && !(r_flush || i_flush)) begin
          r_i_rvalid <= 1'b1;
          r_i_rdata  <= m_rdata;
        end
      end else if (r_state == INST && i_flush) begin
        r_flush <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b)                           r_starve <= '0;
    else if (!i_req || w_ignt)           r_starve <= '0;
    else if (w_dgnt && r_starve < LIM)   r_starve <= r_starve + STARVE_W'(1);
  end

  assign d_gnt    = w_dgnt;
  assign i_gnt    = w_ignt;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed and randomized bench for cpu_mem_arbiter against a transaction-level model.
module tb_cpu_mem_arbiter;
  import cpu_mem_pkg::*;

  localparam int LIM = STARVE_LIMIT_DEF;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        i_req = 1'b0, i_flush = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [47:0] i_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr;
  logic [47:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [47:0] m_rdata = '0;

  cpu_mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_b(rst_b),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: one outstanding transaction record plus pending responses
  bit          b_busy, b_fetch, b_we, b_fl, b_pd, b_pi;
  logic [31:0] b_addr, b_dr;
  logic [47:0] b_wdata, b_ir;
  int          b_starve;

  // last sampled DUT outputs, for the directed checks
  bit          o_dg, o_ig, o_mreq, o_mwe, o_drv, o_irv;
  logic [31:0] o_maddr, o_dr;
  logic [47:0] o_mwdata, o_ir;

  int ack_lat = 1;
  int age     = 0;
  bit rnd_mem = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    b_busy = 0; b_fetch = 0; b_we = 0; b_fl = 0; b_pd = 0; b_pi = 0;
    b_addr = '0; b_dr = '0; b_wdata = '0; b_ir = '0; b_starve = 0;
  endtask

  task automatic drive_mem();
    if (m_req) begin
      age++;
      if (rnd_mem && age == 1) ack_lat = $urandom_range(1, 3);
      m_ack = (age >= ack_lat);
    end else begin
      age   = 0;
      m_ack = rnd_mem && ($urandom_range(0, 4) == 0);
    end
    if (rnd_mem) m_rdata = {16'($urandom), $urandom};
  endtask

  // one clock cycle: compare at the falling edge, advance the model, then
  // return just after the next rising edge with the memory responder updated
  task automatic step();
    bit e_dg, e_ig;
    @(negedge clk);
    o_dg = d_gnt; o_ig = i_gnt; o_mreq = m_req; o_mwe = m_we; o_maddr = m_addr;
    o_mwdata = m_wdata; o_drv = d_rvalid; o_dr = d_rdata; o_irv = i_rvalid; o_ir = i_rdata;
    if (rst_b) begin
      chk("rst_ctl", 64'({m_req, m_we, d_gnt, i_gnt, d_rvalid, i_rvalid}), 64'(0));
      chk("rst_m_addr", 64'(m_addr), 64'(0));
      chk("rst_m_wdata", 64'(m_wdata), 64'(0));
      chk("rst_d_rdata", 64'(d_rdata), 64'(0));
      chk("rst_i_rdata", 64'(i_rdata), 64'(0));
      model_reset();
    end else begin
      e_dg = !b_busy && d_req && !(i_req && b_starve == LIM);
      e_ig = !b_busy && i_req && !e_dg;
      chk("d_gnt", 64'(d_gnt), 64'(e_dg));
      chk("i_gnt", 64'(i_gnt), 64'(e_ig));
      chk("m_req", 64'(m_req), 64'(b_busy));
      if (b_busy) begin
        chk("m_addr", 64'(m_addr), 64'(b_addr));
        chk("m_we", 64'(m_we), 64'(b_we));
        if (b_fetch || b_we) chk("m_wdata", 64'(m_wdata), 64'(b_wdata));
      end
      chk("d_rvalid", 64'(d_rvalid), 64'(b_pd));
      chk("d_rdata", 64'(d_rdata), 64'(b_dr));
      chk("i_rvalid", 64'(i_rvalid), 64'(b_pi));
      chk("i_rdata", 64'(i_rdata), 64'(b_ir));
      b_pd = 0;
      b_pi = 0;
      if (b_busy) begin
        if (b_fetch && i_flush) b_fl = 1;
        if (m_ack) begin
          b_busy = 0;
          if (!b_fetch && !b_we) begin b_pd = 1; b_dr = m_rdata[31:0]; end
          if (b_fetch && !b_fl)  begin b_pi = 1; b_ir = m_rdata; end
        end
      end
      if (!i_req || e_ig)                b_starve = 0;
      else if (e_dg && b_starve < LIM)   b_starve++;
      if (e_dg) begin
        b_busy = 1; b_fetch = 0; b_we = d_we; b_addr = d_addr;
        b_wdata = d_we ? {16'h0, d_wdata} : 48'h0;
      end
      if (e_ig) begin
        b_busy = 1; b_fetch = 1; b_we = 0; b_addr = i_addr; b_wdata = '0; b_fl = i_flush;
      end
    end
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic rnd_drive();
    if (!d_req || o_dg) begin
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = ($urandom_range(0, 1) == 1);
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    if (!i_req || o_ig) begin
      i_req  = ($urandom_range(0, 2) != 0);
      i_addr = $urandom;
    end
    i_flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int nd0, nd1, n_ig;
    model_reset();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;

    // read with a 2-cycle ack, granted in the first cycle out of reset
    d_req = 1; d_addr = 32'h100; d_we = 0; ack_lat = 2; m_rdata = 48'hAAAA_DEADBEEF;
    step(); chk("rd_gnt_N", 64'(o_dg), 64'(1));
    d_req = 0;
    step(); chk("rd_mreq_N1", 64'(o_mreq), 64'(1)); chk("rd_addr", 64'(o_maddr), 64'h100);
    step(); chk("rd_mreq_N2", 64'(o_mreq), 64'(1)); chk("rd_norv_N2", 64'(o_drv), 64'(0));
    step(); chk("rd_rvalid_N3", 64'(o_drv), 64'(1)); chk("rd_rdata", 64'(o_dr), 64'hDEADBEEF);
    chk("rd_mreq_N3", 64'(o_mreq), 64'(0));

    // simultaneous requests: data first, fetch at the next IDLE cycle
    ack_lat = 1; d_req = 1; d_addr = 32'h104; i_req = 1; i_addr = 32'h10;
    step(); chk("pri_dgnt", 64'(o_dg), 64'(1)); chk("pri_no_igt", 64'(o_ig), 64'(0));
    d_req = 0;
    step(); chk("pri_busy_no_igt", 64'(o_ig), 64'(0));
    step(); chk("pri_igt", 64'(o_ig), 64'(1));
    i_req = 0;
    step();
    step(); chk("pri_irv", 64'(o_irv), 64'(1)); chk("pri_irdata", 64'(o_ir), 64'hAAAA_DEADBEEF);

    // starvation: held requests, writes with 1-cycle ack
    d_req = 1; d_we = 1; i_req = 1; nd0 = 0; nd1 = 0; n_ig = 0;
    for (int c = 0; c < 40 && n_ig < 2; c++) begin
      d_wdata = $urandom;
      step();
      if (o_dg) begin
        if (n_ig == 0) nd0++;
        else           nd1++;
      end
      if (o_ig) n_ig++;
    end
    chk("starve_d_before_i", 64'(nd0), 64'(4));
    chk("starve_d_after_clear", 64'(nd1), 64'(4));
    chk("starve_fetches", 64'(n_ig), 64'(2));
    d_req = 0; i_req = 0; d_we = 0;
    repeat (3) step();

    // flush in the ack cycle of a fetch
    ack_lat = 3; i_req = 1; i_addr = 32'h40;
    step(); chk("fl_igt", 64'(o_ig), 64'(1));
    i_req = 0;
    step(); chk("fl_mreq1", 64'(o_mreq), 64'(1)); chk("fl_addr", 64'(o_maddr), 64'h40);
    chk("fl_we", 64'(o_mwe), 64'(0));
    step(); chk("fl_mreq2", 64'(o_mreq), 64'(1));
    i_flush = 1;
    step(); chk("fl_mreq3", 64'(o_mreq), 64'(1));
    i_flush = 0;
    step(); chk("fl_no_irv", 64'(o_irv), 64'(0)); chk("fl_mreq_done", 64'(o_mreq), 64'(0));
    step(); chk("fl_no_irv_late", 64'(o_irv), 64'(0));

    // reset in the middle of a fetch, then a stray ack
    ack_lat = 3; i_req = 1; i_addr = 32'h80;
    step(); chk("rs_igt", 64'(o_ig), 64'(1));
    i_req = 0;
    step(); chk("rs_mreq", 64'(o_mreq), 64'(1));
    rst_b = 1;
    step(); chk("rs_mreq_now", 64'(o_mreq), 64'(0));
    rst_b = 0; m_ack = 1;
    step(); chk("rs_ack_no_irv", 64'(o_irv), 64'(0)); chk("rs_mreq_idle", 64'(o_mreq), 64'(0));
    d_req = 1; d_we = 0; d_addr = 32'h300; ack_lat = 1;
    step(); chk("rs_idle_gnt", 64'(o_dg), 64'(1)); chk("rs_no_irv", 64'(o_irv), 64'(0));
    d_req = 0;
    repeat (2) step();

    // write: zero-extended data, no read response, payload change after grant ignored
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
    step(); chk("wr_gnt", 64'(o_dg), 64'(1));
    d_req = 0; d_wdata = 32'hFFFF_FFFF; d_addr = 32'h0;
    step(); chk("wr_mwdata", 64'(o_mwdata), 64'h0000_12345678); chk("wr_mwe", 64'(o_mwe), 64'(1));
    chk("wr_maddr", 64'(o_maddr), 64'h200);
    step(); chk("wr_no_drv", 64'(o_drv), 64'(0));
    d_we = 0;

    // randomized traffic, flushes, stray acks and occasional resets
    rnd_mem = 1;
    for (int c = 0; c < 3000; c++) begin
      rst_b = ($urandom_range(0, 199) == 0);
      rnd_drive();
      step();
    end
    rst_b = 0; d_req = 0; i_req = 0; i_flush = 0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
